// File: rtl/period_pkg.sv
// Shared definitions for the period measurement path and its downstream
// stability checker.
package period_pkg;

  localparam int PERIOD_W = 32;
  localparam logic [PERIOD_W-1:0] PERIOD_INVALID = 32'd0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARM     = ST_ARM,
    MEASURE = ST_MEASURE
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level plus a rising-edge
// detector on the synchronised copy.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync_prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = async_in;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
    end else begin
      sync_reg      <= sync_next;
      sync_prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_prev_reg;

endmodule

// File: rtl/period_meter.sv
// Measures the period of an asynchronous signal in clk cycles between
// successive synchronised rising edges; 0 means no valid measurement.
module period_meter
  import period_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_WIDTH   = 32,
  parameter int unsigned TIMEOUT     = 1048575
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                PWRDWN,
  input  logic                sig_in,
  output logic [PERIOD_W-1:0] period_length,
  output logic                period_update,
  output logic                sig_lost
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Power-down and reset clear exactly the same state, so one async clear serves both.
  logic arst;
  assign arst = RST | PWRDWN;

  logic sync_level;
  logic rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .RST      (arst),
    .async_in (sig_in),
    .sync_out (sync_level),
    .rise     (rise)
  );

  state_e               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0] len_reg, len_next;
  logic                 upd_reg, upd_next;
  logic                 lost_reg, lost_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    upd_next   = 1'b0;
    lost_next  = lost_reg;
    case (state_reg)
      IDLE: begin
        state_next = ARM;
        cnt_next   = '0;
      end
      ARM: begin
        cnt_next = '0;
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = CNT_ONE;
        end
      end
      MEASURE: begin
        // A rise coinciding with the timeout still counts as a period of TIMEOUT.
        if (rise) begin
          len_next  = cnt_reg;
          upd_next  = 1'b1;
          lost_next = 1'b0;
          cnt_next  = CNT_ONE;
        end else if (cnt_reg == TIMEOUT_C) begin
          len_next   = CNT_WIDTH'(PERIOD_INVALID);
          lost_next  = 1'b1;
          cnt_next   = '0;
          state_next = ARM;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      len_reg   <= CNT_WIDTH'(PERIOD_INVALID);
      upd_reg   <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      upd_reg   <= upd_next;
      lost_reg  <= lost_next;
    end
  end

  assign period_length = PERIOD_W'(len_reg);
  assign period_update = upd_reg;
  assign sig_lost      = lost_reg;

  a_rise_on_level: assert property (@(posedge clk) disable iff (arst) rise |-> sync_level);

endmodule

// File: tb/tb_period_meter.sv
// Randomised and directed bench for period_meter, checked every cycle against
// a reference built from detected-rise timestamps.
module tb_period_meter;

  localparam int SYNC = 2;
  localparam int CW   = 16;
  localparam int TO   = 50;

  logic        clk    = 1'b0;
  logic        RST    = 1'b1;
  logic        PWRDWN = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] period_length;
  logic        period_update;
  logic        sig_lost;

  always #5 clk = ~clk;

  period_meter #(
    .SYNC_STAGES(SYNC),
    .CNT_WIDTH  (CW),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .PWRDWN       (PWRDWN),
    .sig_in       (sig_in),
    .period_length(period_length),
    .period_update(period_update),
    .sig_lost     (sig_lost)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sig_in generator: square wave of gen_period cycles, high for the first half
  int gen_period = 0;
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      if (gen_period == 0) begin
        sig_in = 1'b0;
        phase  = 0;
      end else begin
        if (phase >= gen_period) phase = 0;
        sig_in = (phase < gen_period / 2) ? 1'b1 : 1'b0;
        phase++;
      end
    end
  end

  // Reference: a sampled rise becomes visible SYNC edges later; a measurement is
  // the distance between two visible rises, or a loss once that distance exceeds TO.
  int unsigned edge_n        = 0;
  int unsigned detect_q[$];
  bit          prev_sample   = 1'b0;
  int          mode          = 0;   // 0: just out of reset, 1: waiting for first rise, 2: timing
  int unsigned last_rise     = 0;
  logic [31:0] exp_len       = 0;
  bit          exp_upd       = 1'b0;
  bit          exp_lost      = 1'b0;
  bit          prev_upd      = 1'b0;
  bit          prev_lost     = 1'b0;
  int          n_upd         = 0;
  int unsigned first_upd_val = 0;
  int unsigned last_upd_val  = 0;
  int unsigned last_upd_edge = 0;
  int unsigned lost_edge     = 0;
  int          lost_cycles   = 0;

  initial begin
    bit det;
    forever begin
      @(posedge clk);
      edge_n++;
      if (RST || PWRDWN) begin
        mode        = 0;
        detect_q.delete();
        prev_sample = 1'b0;
        exp_len     = 0;
        exp_upd     = 1'b0;
        exp_lost    = 1'b0;
      end else begin
        det = (detect_q.size() > 0) && (detect_q[0] == edge_n);
        if (det) void'(detect_q.pop_front());
        if (sig_in && !prev_sample) detect_q.push_back(edge_n + SYNC);
        prev_sample = sig_in;
        exp_upd     = 1'b0;
        case (mode)
          0: mode = 1;
          1: if (det) begin
               mode      = 2;
               last_rise = edge_n;
             end
          default: begin
            if (det) begin
              exp_len   = edge_n - last_rise;
              exp_upd   = 1'b1;
              exp_lost  = 1'b0;
              last_rise = edge_n;
            end else if (edge_n - last_rise == TO) begin
              exp_len  = 0;
              exp_lost = 1'b1;
              mode     = 1;
            end
          end
        endcase
      end
      #1;
      check("period_length", period_length, exp_len);
      check("period_update", 32'(period_update), 32'(exp_upd));
      check("sig_lost", 32'(sig_lost), 32'(exp_lost));
      check("no_back_to_back", 32'(period_update & prev_upd), 32'd0);
      prev_upd = period_update;
      if (period_update) begin
        n_upd++;
        if (n_upd == 1) first_upd_val = period_length;
        last_upd_val  = period_length;
        last_upd_edge = edge_n;
        $display("edge %0d: update period_length=%0d", edge_n, period_length);
      end
      if (sig_lost && !prev_lost) begin
        lost_edge = edge_n;
        $display("edge %0d: sig_lost asserted", edge_n);
      end
      prev_lost = sig_lost;
      if (sig_lost) lost_cycles++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_update(input int budget);
    int start;
    start = n_upd;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (n_upd > start) break;
    end
  endtask

  initial begin
    int n_before;
    int lost_before;
    int wait_n;

    // Reset held while sig_in toggles
    gen_period = 3;
    wait_cycles(5);
    gen_period = 0;
    wait_cycles(2);
    #3 RST = 1'b0;

    // Steady period 10
    gen_period = 10;
    wait_cycles(50);
    check("steady_first_len", first_upd_val, 32'd10);
    check("steady_last_len", last_upd_val, 32'd10);
    check("steady_lost", 32'(sig_lost), 32'd0);

    // Period change 10 -> 7
    gen_period = 7;
    wait_cycles(60);
    check("period7_len", last_upd_val, 32'd7);

    // Timeout after a stable period 10
    gen_period = 10;
    wait_cycles(40);
    gen_period = 0;
    wait_cycles(80);
    check("timeout_gap", lost_edge - last_upd_edge, 32'd50);
    check("timeout_lost", 32'(sig_lost), 32'd1);
    check("timeout_len", period_length, 32'd0);

    // Restart at period 12
    gen_period = 12;
    wait_update(100);
    check("restart_len", last_upd_val, 32'd12);
    check("restart_lost", 32'(sig_lost), 32'd0);

    // Asynchronous power-down mid-period
    gen_period = 10;
    wait_cycles(35);
    check("pre_pwrdwn_len", period_length, 32'd10);
    @(posedge clk);
    wait_cycles(3);
    #3 PWRDWN = 1'b1;
    #1;
    check("pwrdwn_async_len", period_length, 32'd0);
    check("pwrdwn_async_upd", 32'(period_update), 32'd0);
    check("pwrdwn_async_lost", 32'(sig_lost), 32'd0);
    wait_cycles(3);
    wait_n = 0;
    while (sig_in && wait_n < 12) begin
      @(posedge clk);
      wait_n++;
    end
    #3 PWRDWN = 1'b0;
    wait_update(60);
    check("post_pwrdwn_len", last_upd_val, 32'd10);

    // Boundary: period exactly TIMEOUT
    gen_period = 0;
    @(posedge clk);
    #3 RST = 1'b1;
    wait_cycles(3);
    #3 RST = 1'b0;
    n_before    = n_upd;
    lost_before = lost_cycles;
    gen_period  = TO;
    wait_cycles(260);
    check("boundary_len", last_upd_val, 32'd50);
    check("boundary_updates", 32'((n_upd - n_before) >= 4), 32'd1);
    check("boundary_no_lost", 32'(lost_cycles - lost_before), 32'd0);

    // Random periods with occasional asynchronous resets
    for (int it = 0; it < 25; it++) begin
      gen_period = $urandom_range(2, 64);
      wait_cycles($urandom_range(20, 160));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #($urandom_range(1, 8));
        if ($urandom_range(0, 1) == 0) RST = 1'b1;
        else PWRDWN = 1'b1;
        #1;
        check("async_clear_len", period_length, 32'd0);
        check("async_clear_lost", 32'(sig_lost), 32'd0);
        wait_cycles($urandom_range(1, 3));
        #3;
        RST    = 1'b0;
        PWRDWN = 1'b0;
      end
    end

    wait_cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of an asynchronous input signal in sampling-clock cycles.
- Publishes the result as a 32-bit `period_length`.
- Sits directly upstream of the period stability checker and drives its `period_length` input.
- A measurement value of 0 means "no valid measurement" and is the value the checker treats as unstable.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on sig_in; legal range 2..4.
- CNT_WIDTH, 32: width of the internal cycle counter; legal range 8..32.
- TIMEOUT, 1048575: maximum count before sig_in is declared lost. Constraints: 2 ≤ TIMEOUT ≤ 2^CNT_WIDTH−1.

Ports:
- clk  input  1  sampling clock.
- RST  input  1  reset; asynchronous, active-high.
- PWRDWN  input  1  power-down; asynchronous, active-high; has priority over RST.
- sig_in  input  1  measured signal, asynchronous to clk.
- period_length  output  32  last measured period in clk cycles, zero-extended from CNT_WIDTH; 0 means invalid.
- period_update  output  1  one-cycle pulse, high in the cycle period_length takes a new measured value.
- sig_lost  output  1  high after a timeout; cleared by the next measured period.

Behaviour:
- Reset/power-down:
  - RST or PWRDWN high forces: state IDLE, cnt=0, all synchroniser flops and the edge-history flop=0, period_length=0, period_update=0, sig_lost=0.
  - While either is high, the block stays in IDLE.
  - IDLE → ARM on the first clk edge with both RST and PWRDWN low.
- Synchronisation:
  - sig_in passes through SYNC_STAGES flops.
  - A rise is `sync_out & ~sync_prev`, where sync_prev is one further flop.
  - Latency from a sig_in rise to rise detection is SYNC_STAGES+1 clk edges (±1 for sampling phase).
- ARM:
  - cnt is held at 0.
  - On rise: go to MEASURE, cnt<=1, no output change.
  - There is no timeout in ARM.
- MEASURE, priority in this order:
  1. Rise: period_length<=cnt, period_update<=1, sig_lost<=0, cnt<=1, stay in MEASURE.
  2. No rise and cnt==TIMEOUT: period_length<=0, sig_lost<=1, period_update<=0, cnt<=0, go to ARM.
  3. Otherwise: cnt<=cnt+1, period_update<=0.
- Measurement semantics:
  - A rise and a timeout in the same cycle resolve as a rise, giving period_length=TIMEOUT.
  - The counter never wraps, because timeout fires at TIMEOUT.
  - Minimum reportable period is 2, since synchronised rises are at least 2 cycles apart.
- Output rules:
  - period_update is never high in two consecutive cycles.
  - period_length holds its value between updates.
- RST or PWRDWN asserted mid-measurement: the in-flight count is discarded with no update pulse; outputs go to the reset values in the same instant.
- Glitches shorter than one clk period may be missed; this is not an error.

Decomposition:
- Shared package `period_pkg`:
  - State enum: IDLE=2'd0, ARM=2'd1, MEASURE=2'd2.
  - Constant PERIOD_W=32.
  - Constant PERIOD_INVALID=32'd0, which is shared with the stability checker.
- Sub-module `sync_edge_detect`, parameterised by SYNC_STAGES:
  - Ports: clk, RST, async_in, sync_out, rise.
  - Reused by later clock-monitoring blocks.

Test Plan:
- Reset values: hold RST high for 5 cycles while toggling sig_in → period_length=0, period_update=0, sig_lost=0 throughout; no update after release until a second rise is seen.
- Steady clock: sig_in with period 10 clk cycles, 40 cycles → first pulse at the second detected rise with period_length=10, then a pulse every 10 cycles with value 10; sig_lost stays 0.
- Period change: switch sig_in from period 10 to period 7 → next update reports a value in 7..10 (transition period), all later updates report 7; pulses never back-to-back.
- Timeout: TIMEOUT=50, stop sig_in after stable period 10 → exactly 50 cycles after the last rise, period_length=0 and sig_lost=1 with no pulse. Restarting sig_in at period 12 → first pulse reports 12 and clears sig_lost.
- Asynchronous mid-measurement: assert PWRDWN for 3 cycles between clk edges mid-period → outputs drop to 0 immediately without waiting for a clk edge. After release, ARM discards the first rise and reports 10 at the second.
- Boundary: sig_in at period TIMEOUT exactly (TIMEOUT=50, period 50) → period_length=50 each update, sig_lost never asserted.
